// File: rtl/shake_squeeze_if.sv
// Output lane stream of the SHAKE squeeze sequencer (64-bit word + valid/ready).
// With SQUEEZE_LAST_EN defined the stream also carries out_last.
interface shake_squeeze_if;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef SQUEEZE_LAST_EN
  logic        out_last;
`endif

  modport master (
`ifdef SQUEEZE_LAST_EN
    output out_last,
`endif
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
`ifdef SQUEEZE_LAST_EN
    input  out_last,
`endif
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/shake_squeeze.sv
// SHAKE squeeze sequencer: emits rate lanes of a Keccak-f state, one per handshake,
// and asks for a fresh permutation when the rate is used up. Macro SQUEEZE_LAST_EN adds out_last.
module shake_squeeze #(
  parameter int RATE_LANES = 21,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] num_lanes_i,
  input  logic [1599:0]    state_in_i,
  input  logic             state_valid_i,
  output logic             state_ready_o,
  output logic             perm_req_o,
  output logic [1599:0]    perm_state_out_o,
  output logic             busy_o,
  output logic             done_o,
  shake_squeeze_if.master  out_if
);

  if (RATE_LANES < 1 || RATE_LANES > 25) begin : g_bad_rate
    $error("shake_squeeze: RATE_LANES must be 1..25");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_PERM} state_e;

  localparam logic [4:0]       LAST_IDX = 5'(RATE_LANES - 1);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO      = LEN_W'(2);

  state_e                  state_q, state_d;
  logic [24:0][63:0]       buf_q, buf_d;
  logic [4:0]              lane_idx_q, lane_idx_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic [63:0]             out_data_q, out_data_d;
  logic                    done_q, done_d;
  logic                    last_q, last_d;
  logic [4:0]              lane_nxt;

  assign lane_nxt = lane_idx_q + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      lane_idx_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      lane_idx_q  <= lane_idx_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    lane_idx_d  = lane_idx_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    last_d      = last_q;
    unique case (state_q)
      S_IDLE: begin
        // A start coinciding with done is dropped; it is sampled again next cycle.
        if (start_i && !done_q) begin
          if (num_lanes_i != '0) begin
            remaining_d = num_lanes_i;
            state_d     = S_WAIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (state_valid_i) begin
          buf_d      = state_in_i;
          lane_idx_d = '0;
          out_data_d = state_in_i[63:0];
          last_d     = (remaining_q == ONE);
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_if.out_ready) begin
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) begin
            done_d  = 1'b1;
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else if (lane_idx_q == LAST_IDX) begin
            last_d  = 1'b0;
            state_d = S_PERM;
          end else begin
            lane_idx_d = lane_nxt;
            out_data_d = buf_q[lane_nxt];
            last_d     = (remaining_q == TWO);
          end
        end
      end
      S_PERM: state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  // The buffer only changes on capture, so it doubles as the state handed back.
  assign perm_state_out_o = buf_q;
  assign state_ready_o    = (state_q == S_WAIT);
  assign perm_req_o       = (state_q == S_PERM);
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = done_q;
  assign out_if.out_valid = (state_q == S_EMIT);
  assign out_if.out_data  = out_data_q;
`ifdef SQUEEZE_LAST_EN
  assign out_if.out_last  = last_q;
`else
  logic unused_last;
  assign unused_last = last_q;
`endif

endmodule

// File: tb/tb_shake_squeeze.sv
// Directed bench for shake_squeeze: single block, block boundary, backpressure,
// zero length, reset mid-job, and out_last when SQUEEZE_LAST_EN is defined.
module tb_shake_squeeze;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   num_lanes;
  logic [1599:0] state_in;
  logic          state_valid;
  logic          state_ready;
  logic          perm_req;
  logic [1599:0] perm_state_out;
  logic          busy;
  logic          done;

  shake_squeeze_if oif();

  shake_squeeze #(.RATE_LANES(21), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .num_lanes_i(num_lanes),
    .state_in_i(state_in), .state_valid_i(state_valid), .state_ready_o(state_ready),
    .perm_req_o(perm_req), .perm_state_out_o(perm_state_out), .busy_o(busy),
    .done_o(done), .out_if(oif.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1599:0] mk_state(input logic [63:0] base);
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[i*64 +: 64] = base + 64'(i);
    return s;
  endfunction

  // Monitor: handshakes, pulses and stall stability, sampled on the falling edge.
  logic [63:0]   hs_q[$];
  int            hs_cyc[$];
  bit            lst_q[$];
  int            perm_cnt, done_cnt, done_cyc, cap_cyc;
  bit            ov_seen, sr_seen, prev_stall;
  logic [63:0]   prev_data;
  logic [1599:0] exp_perm;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (oif.out_valid && oif.out_ready) begin
      hs_q.push_back(oif.out_data);
      hs_cyc.push_back(cyc);
`ifdef SQUEEZE_LAST_EN
      lst_q.push_back(oif.out_last);
`endif
    end
    if (prev_stall && oif.out_valid) chk("stall_hold", oif.out_data, prev_data);
    prev_stall = oif.out_valid && !oif.out_ready;
    prev_data  = oif.out_data;
    if (perm_req) begin
      perm_cnt++;
      chk("perm_state", 64'(perm_state_out == exp_perm), 64'd1);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (state_valid && state_ready) cap_cyc = cyc;
    if (state_ready) sr_seen = 1'b1;
    if (oif.out_valid) ov_seen = 1'b1;
  end

  task automatic clear();
    hs_q.delete(); hs_cyc.delete(); lst_q.delete();
    perm_cnt = 0; done_cnt = 0; done_cyc = -1; cap_cyc = -1;
    ov_seen = 1'b0; sr_seen = 1'b0; prev_stall = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; num_lanes = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [1599:0] s);
    for (int i = 0; i < 200; i++) begin
      if (state_ready) begin
        state_in = s; state_valid = 1'b1;
        @(posedge clk); #1;
        state_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("feed_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      if (done) return;
      @(posedge clk); #1;
    end
    chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [1599:0] st_a, st_b, st_c, st_d, st_e;
  bit            found;
  int            nlast;
  logic [1:0]    pat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    st_a = mk_state(64'h0);
    st_b = mk_state(64'hA0);
    st_c = mk_state(64'hC0DE_0000_0000_0000);
    st_d = mk_state(64'hD000);
    st_e = mk_state(64'hE000);
    rst_n = 1'b0; start = 1'b0; num_lanes = '0; state_in = '0; state_valid = 1'b0;
    oif.out_ready = 1'b0;
    clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sready", 64'(state_ready), 64'd0);
    chk("rst_perm", 64'(perm_req), 64'd0);
    chk("rst_ovalid", 64'(oif.out_valid), 64'd0);
    chk("rst_odata", oif.out_data, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pstate", 64'(perm_state_out == '0), 64'd1);
    rst_n = 1'b1;
    settle(1);

    // single block
    clear(); oif.out_ready = 1'b1; exp_perm = st_a;
    do_start(16'd3); feed(st_a); wait_done(200); settle(2);
    chk("t1_cnt", 64'(hs_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("t1_lane", hs_q[i], 64'(i));
    chk("t1_latency", 64'(hs_cyc[0]), 64'(cap_cyc + 1));
    chk("t1_consec", 64'(hs_cyc[2] - hs_cyc[0]), 64'd2);
    chk("t1_done_cyc", 64'(done_cyc), 64'(hs_cyc[2] + 1));
    chk("t1_perm", 64'(perm_cnt), 64'd0);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);

    // block boundary
    clear(); exp_perm = st_a;
    do_start(16'd23); feed(st_a); feed(st_b); wait_done(300); settle(2);
    chk("t2_cnt", 64'(hs_q.size()), 64'd23);
    for (int i = 0; i < 21; i++) chk("t2_lane", hs_q[i], 64'(i));
    chk("t2_lane21", hs_q[21], 64'hA0);
    chk("t2_lane22", hs_q[22], 64'hA1);
    chk("t2_perm", 64'(perm_cnt), 64'd1);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);

    // backpressure: out_ready 0,0,1,0,1
    clear(); oif.out_ready = 1'b0; exp_perm = st_c;
    do_start(16'd2); feed(st_c);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (oif.out_valid) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t3_ovalid", 64'(found), 64'd1);
    for (int k = 0; k < 5; k++) begin
      pat = (k == 2 || k == 4) ? 2'd1 : 2'd0;
      oif.out_ready = pat[0];
      @(posedge clk); #1;
    end
    oif.out_ready = 1'b1;
    wait_done(50); settle(2);
    chk("t3_cnt", 64'(hs_q.size()), 64'd2);
    chk("t3_lane0", hs_q[0], 64'hC0DE_0000_0000_0000);
    chk("t3_lane1", hs_q[1], 64'hC0DE_0000_0000_0001);
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);

    // zero length
    clear();
    do_start(16'd0);
    chk("t4_done", 64'(done), 64'd1);
    settle(5);
    chk("t4_ovalid", 64'(ov_seen), 64'd0);
    chk("t4_sready", 64'(sr_seen), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);

    // reset while lane 5 is being offered
    clear(); exp_perm = st_d;
    do_start(16'd30); feed(st_d);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (oif.out_valid && oif.out_data == 64'hD005) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t5_lane5", 64'(found), 64'd1);
    rst_n = 1'b0; #1;
    chk("t5_ovalid", 64'(oif.out_valid), 64'd0);
    chk("t5_odata", oif.out_data, 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_pstate", 64'(perm_state_out == '0), 64'd1);
    settle(2);
    rst_n = 1'b1;
    settle(2);
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    clear(); exp_perm = st_e;
    do_start(16'd1); feed(st_e); wait_done(50); settle(2);
    chk("t5_cnt", 64'(hs_q.size()), 64'd1);
    chk("t5_new_lane0", hs_q[0], 64'hE000);
    chk("t5_done_cnt", 64'(done_cnt), 64'd1);

`ifdef SQUEEZE_LAST_EN
    clear(); exp_perm = st_a;
    do_start(16'd22); feed(st_a); feed(st_b); wait_done(300); settle(2);
    chk("t6_cnt", 64'(hs_q.size()), 64'd22);
    nlast = 0;
    foreach (lst_q[i]) if (lst_q[i]) nlast++;
    chk("t6_nlast", 64'(nlast), 64'd1);
    chk("t6_last_pos", 64'(lst_q[21]), 64'd1);
    chk("t6_lane21", hs_q[21], 64'hA0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
